chnl_host_emulator: RTL and testbench

- Stands in for the PCIe channel side of a RIFFA-style channel, so user logic bandwidth and correctness can be measured on the FPGA without host software.
- Drives a host-to-FPGA (CHNL_RX_*) transfer carrying a counting pattern.
- Sinks the FPGA-to-host (CHNL_TX_*) transfer, checks its pattern, and counts total cycles.
- Instantiated in the bandwidth test top, wired port-for-port to USER_LOGIC.

---
 rtl/chnl_host_emulator_if.sv | 41 ++++
 rtl/chnl_host_emulator.sv | 183 ++++++++++++++++++
 tb/tb_chnl_host_emulator.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chnl_host_emulator_if.sv
// RIFFA-style channel bundle between the host-side emulator (master) and
// the user logic under test (slave).
interface chnl_host_emulator_if #(
    parameter int C_PCI_DATA_WIDTH = 128
);
    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [31:0]                 CHNL_RX_LEN;
    logic [30:0]                 CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;

    logic                        CHNL_TX;
    logic                        CHNL_TX_ACK;
    logic                        CHNL_TX_LAST;
    logic [31:0]                 CHNL_TX_LEN;
    logic [30:0]                 CHNL_TX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
    logic                        CHNL_TX_DATA_VALID;
    logic                        CHNL_TX_DATA_REN;

    modport master (
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
               CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        input  CHNL_RX_ACK, CHNL_RX_DATA_REN,
        input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
               CHNL_TX_DATA, CHNL_TX_DATA_VALID,
        output CHNL_TX_ACK, CHNL_TX_DATA_REN
    );

    modport slave (
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
               CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        output CHNL_RX_ACK, CHNL_RX_DATA_REN,
        output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
               CHNL_TX_DATA, CHNL_TX_DATA_VALID,
        input  CHNL_TX_ACK, CHNL_TX_DATA_REN
    );
endinterface

// File: rtl/chnl_host_emulator.sv
// Host-side channel emulator: sources a counting pattern on RX, sinks and
// checks the returned TX stream, and counts the cycles a test takes.
module chnl_host_emulator #(
    parameter int C_PCI_DATA_WIDTH = 128
) (
    input  logic                        CLK,
    input  logic                        RST_X,
    input  logic                        start,
    input  logic [31:0]                 len,
    input  logic                        rx_stall,
    input  logic                        tx_stall,
    chnl_host_emulator_if.master        chnl,
    output logic                        busy,
    output logic                        done,
    output logic                        err_len,
    output logic [15:0]                 err_cnt,
    output logic [C_PCI_DATA_WIDTH-1:0] tx_first,
    output logic [31:0]                 cycles
);
    localparam int unsigned W   = C_PCI_DATA_WIDTH / 32;
    localparam logic [32:0] W33 = 33'(W);

    typedef enum logic [1:0] {RX_IDLE, RX_REQ, RX_DATA, RX_FIN} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_ACK, TX_DATA, TX_FIN} tx_state_t;

    rx_state_t rx_state_q, rx_state_d;
    tx_state_t tx_state_q, tx_state_d;

    logic [31:0]                 len_q;
    logic [31:0]                 rx_sent_q;
    logic [31:0]                 tx_word_q;
    logic [31:0]                 tx_k_q;
    logic [31:0]                 tx_beats_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_len_q;
    logic [15:0]                 err_cnt_q;
    logic [C_PCI_DATA_WIDTH-1:0] tx_first_q;
    logic [31:0]                 cycles_q;

    logic                        start_ok;
    logic                        run_ok;
    logic                        rx_xfer;
    logic                        rx_last;
    logic                        tx_ren;
    logic                        tx_xfer;
    logic                        tx_last_beat;
    logic                        both_fin;
    logic                        tx_mis;
    logic [C_PCI_DATA_WIDTH-1:0] rx_pat;
    logic [32:0]                 tx_len_rnd;
    logic [32:0]                 tx_beats_w;
    logic [31:0]                 tx_beats_d;
    logic                        unused_ok;

    assign start_ok     = start && !busy_q;
    assign run_ok       = start_ok && (len != 32'd0);
    assign rx_xfer      = (rx_state_q == RX_DATA) && !rx_stall && chnl.CHNL_RX_DATA_REN;
    // widened so a length near 2^32 cannot wrap the final-beat test
    assign rx_last      = ({1'b0, rx_sent_q} + W33) >= {1'b0, len_q};
    assign tx_ren       = (tx_state_q == TX_DATA) && !tx_stall;
    assign tx_xfer      = tx_ren && chnl.CHNL_TX_DATA_VALID;
    assign tx_last_beat = (tx_k_q + 32'd1) == tx_beats_q;
    assign both_fin     = (rx_state_q == RX_FIN) && (tx_state_q == TX_FIN);

    assign tx_len_rnd   = {1'b0, chnl.CHNL_TX_LEN} + (W33 - 33'd1);
    assign tx_beats_w   = tx_len_rnd / W33;
    assign tx_beats_d   = (chnl.CHNL_TX_LEN == 32'd0) ? 32'd1 : tx_beats_w[31:0];
    assign unused_ok    = ^{chnl.CHNL_TX_LAST, chnl.CHNL_TX_OFF, tx_beats_w[32]};

    assign chnl.CHNL_RX            = (rx_state_q == RX_REQ) || (rx_state_q == RX_DATA);
    assign chnl.CHNL_RX_LAST       = 1'b1;
    assign chnl.CHNL_RX_LEN        = len_q;
    assign chnl.CHNL_RX_OFF        = '0;
    assign chnl.CHNL_RX_DATA       = (rx_state_q == RX_DATA) ? rx_pat : '0;
    assign chnl.CHNL_RX_DATA_VALID = (rx_state_q == RX_DATA) && !rx_stall;
    assign chnl.CHNL_TX_ACK        = (tx_state_q == TX_ACK);
    assign chnl.CHNL_TX_DATA_REN   = tx_ren;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_len  = err_len_q;
    assign err_cnt  = err_cnt_q;
    assign tx_first = tx_first_q;
    assign cycles   = cycles_q;

    // Per-lane RX pattern for the current beat and TX lane mismatch detect
    always_comb begin
        rx_pat = '0;
        tx_mis = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            rx_pat[32*i +: 32] = rx_sent_q + i + 32'd1;
            if (chnl.CHNL_TX_DATA[32*i +: 32] != tx_word_q + i + 32'd1) begin
                tx_mis = 1'b1;
            end
        end
    end

    // Next-state logic for the RX source and TX sink FSMs
    always_comb begin
        rx_state_d = rx_state_q;
        tx_state_d = tx_state_q;
        unique case (rx_state_q)
            RX_IDLE: if (run_ok) rx_state_d = RX_REQ;
            RX_REQ:  if (chnl.CHNL_RX_ACK) rx_state_d = RX_DATA;
            RX_DATA: if (rx_xfer && rx_last) rx_state_d = RX_FIN;
            RX_FIN:  if (both_fin) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
        unique case (tx_state_q)
            // armed only while a test is running
            TX_IDLE: if (busy_q && chnl.CHNL_TX) tx_state_d = TX_ACK;
            TX_ACK:  tx_state_d = TX_DATA;
            TX_DATA: if (tx_xfer && tx_last_beat) tx_state_d = TX_FIN;
            TX_FIN:  if (both_fin) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // FSM state registers
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
        end
    end

    // Test control, counters, TX checking and result capture
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            len_q      <= '0;
            rx_sent_q  <= '0;
            tx_word_q  <= '0;
            tx_k_q     <= '0;
            tx_beats_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
            err_cnt_q  <= '0;
            tx_first_q <= '0;
            cycles_q   <= '0;
        end else if (start_ok) begin
            len_q      <= len;
            rx_sent_q  <= '0;
            tx_word_q  <= '0;
            tx_k_q     <= '0;
            tx_beats_q <= '0;
            busy_q     <= (len != 32'd0);
            done_q     <= (len == 32'd0);
            err_len_q  <= (len == 32'd0);
            err_cnt_q  <= '0;
            tx_first_q <= '0;
            cycles_q   <= '0;
        end else begin
            if (busy_q && (cycles_q != '1)) begin
                cycles_q <= cycles_q + 32'd1;
            end
            if (both_fin) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (rx_xfer) begin
                rx_sent_q <= rx_sent_q + 32'(W);
            end
            if (tx_state_q == TX_ACK) begin
                tx_beats_q <= tx_beats_d;
                if (chnl.CHNL_TX_LEN != len_q) err_len_q <= 1'b1;
            end
            if (tx_xfer) begin
                if (tx_k_q == 32'd0) begin
                    tx_first_q <= chnl.CHNL_TX_DATA;
                end else if (tx_mis && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
                tx_k_q    <= tx_k_q + 32'd1;
                tx_word_q <= tx_word_q + 32'(W);
            end
        end
    end
endmodule

// File: tb/tb_chnl_host_emulator.sv
// Directed bench: the bench plays USER_LOGIC, returning either a loopback
// (first TX beat = last RX beat, then the counting pattern) or a fixed header.
module tb_chnl_host_emulator;
    localparam int DW = 128;
    localparam int W  = DW / 32;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   len = '0;
    logic          rx_stall = 1'b0;
    logic          tx_stall = 1'b0;
    logic          busy, done, err_len;
    logic [15:0]   err_cnt;
    logic [DW-1:0] tx_first;
    logic [31:0]   cycles;

    int checks = 0;
    int errors = 0;
    bit meas_go = 1'b0;
    int meas_cnt = 0;

    chnl_host_emulator_if #(.C_PCI_DATA_WIDTH(DW)) chnl ();

    chnl_host_emulator #(.C_PCI_DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST_X(RST_X), .start(start), .len(len),
        .rx_stall(rx_stall), .tx_stall(tx_stall), .chnl(chnl),
        .busy(busy), .done(done), .err_len(err_len), .err_cnt(err_cnt),
        .tx_first(tx_first), .cycles(cycles)
    );

    always #5 CLK = ~CLK;

    // reference cycle count: negedges after the accepting edge until done shows
    always @(negedge CLK) begin
        if (meas_go) meas_cnt = done ? 0 : 1;
        else if (!done) meas_cnt = meas_cnt + 1;
    end

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) p[32*i +: 32] = 32'(W*k + i + 1);
        return p;
    endfunction

    task automatic pulse_start(input logic [31:0] l);
        start = 1'b1; len = l;
        #1 meas_go = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        #1 meas_go = 1'b0;
    endtask

    task automatic rx_sink(input int stop, input bit stall, output int nb,
                           output logic [DW-1:0] last, output int bad);
        int c;
        nb = 0; bad = 0; last = '0; c = 0;
        while (!chnl.CHNL_RX && c < 50) begin @(negedge CLK); #1; c++; end
        if (!chnl.CHNL_RX) begin bad++; return; end
        chnl.CHNL_RX_ACK = 1'b1;
        @(negedge CLK);
        chnl.CHNL_RX_ACK = 1'b0;
        for (c = 0; c < 400; c++) begin
            chnl.CHNL_RX_DATA_REN = stall ? ((c % 5) != 2) : 1'b1;
            rx_stall = stall ? (((c / 3) % 2) == 1) : 1'b0;
            #1;
            if (!chnl.CHNL_RX) break;
            if (chnl.CHNL_RX_DATA !== pat(nb)) bad++;
            if (chnl.CHNL_RX_DATA_VALID !== !rx_stall) bad++;
            if (chnl.CHNL_RX_DATA_VALID && chnl.CHNL_RX_DATA_REN) begin
                last = chnl.CHNL_RX_DATA;
                nb++;
                if (nb == stop) return;
            end
            @(negedge CLK);
        end
        if (c >= 400) bad++;
        rx_stall = 1'b0;
        chnl.CHNL_RX_DATA_REN = 1'b0;
    endtask

    task automatic tx_source(input int tl, input logic [DW-1:0] first, input int corrupt,
                             input bit stall, output int bad);
        int c, k, nbeats;
        logic [DW-1:0] d;
        bad = 0; k = 0; c = 0;
        nbeats = (tl == 0) ? 1 : (tl + W - 1) / W;
        chnl.CHNL_TX = 1'b1; chnl.CHNL_TX_LEN = 32'(tl);
        while (!chnl.CHNL_TX_ACK && c < 50) begin @(negedge CLK); #1; c++; end
        chnl.CHNL_TX = 1'b0;
        if (!chnl.CHNL_TX_ACK) begin bad++; return; end
        @(negedge CLK);
        for (c = 0; c < 400 && k < nbeats; c++) begin
            tx_stall = stall ? (((c / 3) % 2) == 1) : 1'b0;
            d = (k == 0) ? first : pat(k);
            if (k == corrupt) d[0] = ~d[0];
            chnl.CHNL_TX_DATA = d; chnl.CHNL_TX_DATA_VALID = 1'b1;
            #1;
            if (chnl.CHNL_TX_DATA_REN !== !tx_stall) bad++;
            if (chnl.CHNL_TX_DATA_REN) k++;
            @(negedge CLK);
        end
        chnl.CHNL_TX_DATA_VALID = 1'b0; tx_stall = 1'b0;
        #1;
        if (k < nbeats) bad++;
        if (chnl.CHNL_TX_DATA_REN !== 1'b0) bad++;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 200) begin @(negedge CLK); #1; c++; end
    endtask

    task automatic test_reset();
        @(negedge CLK); #1;
        checks++;
        if ({chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID, chnl.CHNL_TX_ACK, chnl.CHNL_TX_DATA_REN,
             busy, done, err_len} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000000", {chnl.CHNL_RX,
                chnl.CHNL_RX_DATA_VALID, chnl.CHNL_TX_ACK, chnl.CHNL_TX_DATA_REN, busy, done, err_len});
        end
        checks++;
        if ({chnl.CHNL_RX_DATA, chnl.CHNL_RX_LEN, err_cnt, tx_first, cycles} !== '0) begin
            errors++; $display("FAIL reset_words got data=%h len=%h cnt=%h first=%h cyc=%h want all 0",
                chnl.CHNL_RX_DATA, chnl.CHNL_RX_LEN, err_cnt, tx_first, cycles);
        end
        @(negedge CLK); RST_X = 1'b1;
        @(negedge CLK); #1;
    endtask

    task automatic test_loopback4();
        int nb, rb, tb;
        logic [DW-1:0] last;
        pulse_start(32'd4);
        checks++;
        if (busy !== 1'b1 || chnl.CHNL_RX_LEN !== 32'd4) begin
            errors++; $display("FAIL lb4_start got busy=%b len=%0d want 1 4", busy, chnl.CHNL_RX_LEN);
        end
        rx_sink(0, 1'b0, nb, last, rb);
        checks++;
        if (nb !== 1 || rb !== 0 || last !== pat(0)) begin
            errors++; $display("FAIL lb4_rx got beats=%0d bad=%0d last=%h want 1 0 %h", nb, rb, last, pat(0));
        end
        tx_source(4, last, -1, 1'b0, tb);
        wait_done();
        checks++;
        if (tb !== 0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL lb4_done got bad=%0d done=%b busy=%b want 0 1 0", tb, done, busy);
        end
        checks++;
        if (tx_first !== pat(0) || err_cnt !== 16'd0 || err_len !== 1'b0) begin
            errors++; $display("FAIL lb4_result got first=%h cnt=%0d elen=%b want %h 0 0",
                tx_first, err_cnt, err_len, pat(0));
        end
        checks++;
        if (cycles !== 32'(meas_cnt) || cycles == 32'd0) begin
            errors++; $display("FAIL lb4_cycles got %0d want %0d", cycles, meas_cnt);
        end
    endtask

    task automatic test_loopback64();
        int nb, rb, tb;
        logic [DW-1:0] last;
        pulse_start(32'd64);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL lb64_restart got done=%b busy=%b want 0 1", done, busy);
        end
        start = 1'b1; len = 32'd8;
        @(negedge CLK); start = 1'b0; #1;
        checks++;
        if (chnl.CHNL_RX_LEN !== 32'd64 || busy !== 1'b1) begin
            errors++; $display("FAIL start_while_busy got len=%0d busy=%b want 64 1", chnl.CHNL_RX_LEN, busy);
        end
        rx_sink(0, 1'b0, nb, last, rb);
        checks++;
        if (nb !== 16 || rb !== 0 || last !== pat(15)) begin
            errors++; $display("FAIL lb64_rx got beats=%0d bad=%0d last=%h want 16 0 %h", nb, rb, last, pat(15));
        end
        tx_source(64, last, -1, 1'b0, tb);
        wait_done();
        checks++;
        if (tb !== 0 || done !== 1'b1 || err_cnt !== 16'd0 || err_len !== 1'b0 || tx_first !== pat(15)) begin
            errors++; $display("FAIL lb64_result got bad=%0d done=%b cnt=%0d elen=%b first=%h want 0 1 0 0 %h",
                tb, done, err_cnt, err_len, tx_first, pat(15));
        end
        checks++;
        if (cycles !== 32'(meas_cnt) || cycles == 32'd0) begin
            errors++; $display("FAIL lb64_cycles got %0d want %0d", cycles, meas_cnt);
        end
        repeat (5) @(negedge CLK);
        #1;
        checks++;
        if (cycles !== 32'(meas_cnt) || done !== 1'b1) begin
            errors++; $display("FAIL lb64_frozen got cycles=%0d done=%b want %0d 1", cycles, done, meas_cnt);
        end
    endtask

    task automatic test_stall_concurrent();
        int nb, rb, tb;
        logic [DW-1:0] last;
        logic [DW-1:0] hdr;
        hdr = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        pulse_start(32'd64);
        fork
            rx_sink(0, 1'b1, nb, last, rb);
            tx_source(64, hdr, -1, 1'b1, tb);
        join
        wait_done();
        checks++;
        if (nb !== 16 || rb !== 0 || last !== pat(15)) begin
            errors++; $display("FAIL stall_rx got beats=%0d bad=%0d last=%h want 16 0 %h", nb, rb, last, pat(15));
        end
        checks++;
        if (tb !== 0 || done !== 1'b1 || err_cnt !== 16'd0 || err_len !== 1'b0 || tx_first !== hdr) begin
            errors++; $display("FAIL stall_tx got bad=%0d done=%b cnt=%0d elen=%b first=%h want 0 1 0 0 %h",
                tb, done, err_cnt, err_len, tx_first, hdr);
        end
    endtask

    task automatic test_bad_tx();
        int nb, rb, tb;
        logic [DW-1:0] last;
        pulse_start(32'd64);
        rx_sink(0, 1'b0, nb, last, rb);
        tx_source(60, last, 5, 1'b0, tb);
        wait_done();
        checks++;
        if (rb !== 0 || tb !== 0 || done !== 1'b1) begin
            errors++; $display("FAIL badtx_flow got rxbad=%0d txbad=%0d done=%b want 0 0 1", rb, tb, done);
        end
        checks++;
        if (err_len !== 1'b1 || err_cnt !== 16'd1) begin
            errors++; $display("FAIL badtx_errs got elen=%b cnt=%0d want 1 1", err_len, err_cnt);
        end
    endtask

    task automatic test_len0();
        bit rx_seen, ack_seen;
        pulse_start(32'd0);
        checks++;
        if (err_len !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || cycles !== 32'd0) begin
            errors++; $display("FAIL len0 got elen=%b done=%b busy=%b cyc=%0d want 1 1 0 0",
                err_len, done, busy, cycles);
        end
        rx_seen = 1'b0; ack_seen = 1'b0;
        chnl.CHNL_TX = 1'b1; chnl.CHNL_TX_LEN = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); #1;
            if (chnl.CHNL_RX) rx_seen = 1'b1;
            if (chnl.CHNL_TX_ACK) ack_seen = 1'b1;
        end
        chnl.CHNL_TX = 1'b0;
        checks++;
        if (rx_seen !== 1'b0 || ack_seen !== 1'b0) begin
            errors++; $display("FAIL len0_idle got rx=%b ack=%b want 0 0", rx_seen, ack_seen);
        end
    endtask

    task automatic test_reset_mid();
        int nb, rb, tb;
        logic [DW-1:0] last;
        pulse_start(32'd64);
        rx_sink(3, 1'b0, nb, last, rb);
        RST_X = 1'b0;
        #1;
        checks++;
        if ({chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID, chnl.CHNL_TX_ACK, chnl.CHNL_TX_DATA_REN,
             busy, done, err_len} !== 7'b0 ||
            {chnl.CHNL_RX_DATA, chnl.CHNL_RX_LEN, err_cnt, tx_first, cycles} !== '0) begin
            errors++; $display("FAIL midreset got rx=%b valid=%b busy=%b data=%h len=%0d cyc=%0d want all 0",
                chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID, busy, chnl.CHNL_RX_DATA, chnl.CHNL_RX_LEN, cycles);
        end
        chnl.CHNL_RX_DATA_REN = 1'b0; chnl.CHNL_RX_ACK = 1'b0;
        @(negedge CLK); RST_X = 1'b1;
        @(negedge CLK);
        pulse_start(32'd8);
        rx_sink(0, 1'b0, nb, last, rb);
        tx_source(8, last, -1, 1'b0, tb);
        wait_done();
        checks++;
        if (nb !== 2 || rb !== 0 || tb !== 0 || done !== 1'b1 || err_cnt !== 16'd0 ||
            err_len !== 1'b0 || tx_first !== pat(1)) begin
            errors++; $display("FAIL after_reset got beats=%0d rxbad=%0d txbad=%0d done=%b cnt=%0d elen=%b first=%h want 2 0 0 1 0 0 %h",
                nb, rb, tb, done, err_cnt, err_len, tx_first, pat(1));
        end
    endtask

    initial begin
        chnl.CHNL_RX_ACK = 1'b0; chnl.CHNL_RX_DATA_REN = 1'b0;
        chnl.CHNL_TX = 1'b0; chnl.CHNL_TX_LAST = 1'b1; chnl.CHNL_TX_LEN = '0;
        chnl.CHNL_TX_OFF = '0; chnl.CHNL_TX_DATA = '0; chnl.CHNL_TX_DATA_VALID = 1'b0;
        test_reset();
        test_loopback4();
        test_loopback64();
        test_stall_concurrent();
        test_bad_tx();
        test_len0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
